timer_sched: RTL and testbench

- Shared millisecond-timeout scheduler for the morse decoder.
- Consumes the single-cycle divided-clock tick pulse and prescales it to a 1 ms unit.
- Arbitrates one countdown timer among NUM_REQ requesters, e.g. dot/dash classifier, inter-letter gap detector and word-gap detector.
- Grants the timer round-robin, runs the requested duration, then signals completion with the winner's index.

---
 rtl/timer_sched.sv | 169 ++++++++++++++++
 tb/tb_timer_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// timer_sched: round-robin shared countdown timer in prescaled tick units; TIMER_SCHED_STATUS_EN adds remaining_out/overrun.
// Latency: req->grant 1 cycle, done 1 cycle after expiry; losing requesters simply hold req until served.
module timer_sched #(
    parameter int NUM_REQ  = 4,
    parameter int DUR_W    = 12,
    parameter int PRESCALE = 10000
) (
    input  logic                       clk_100Mhz,
    input  logic                       reset,
    input  logic                       tick_in,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DUR_W-1:0]   dur,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       busy,
    output logic                       done,
`ifdef TIMER_SCHED_STATUS_EN
    output logic [DUR_W-1:0]           remaining_out,
    output logic                       overrun,
`endif
    output logic [$clog2(NUM_REQ)-1:0] done_id
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [PS_W-1:0]    ps_q, ps_d;
    logic [DUR_W-1:0]   rem_q, rem_d;

    logic [ID_W-1:0]    win;
    logic               win_vld;
    logic [ID_W:0]      sum;
    logic [DUR_W-1:0]   dur_win;
    logic               expire;

    // Scan downward so the candidate closest to the rr pointer is the last one written.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        sum     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
            if (req[sum[ID_W-1:0]]) begin
                win     = sum[ID_W-1:0];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        dur_win = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) dur_win = dur[i*DUR_W +: DUR_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        ps_d      = ps_q;
        rem_d     = rem_q;
        expire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = RUN;
                    grant_d = NUM_REQ'(1) << win;
                    busy_d  = 1'b1;
                    owner_d = win;
                    rem_d   = dur_win;
                    ps_d    = '0;
                    rr_d    = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
                end
            end
            RUN: begin
                // A dropped request wins over a simultaneous expiry: no done for a withdrawn owner.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else if (rem_q == '0) begin
                    expire = 1'b1;
                end else if (tick_in) begin
                    if (ps_q == PS_LAST) begin
                        ps_d   = '0;
                        rem_d  = rem_q - DUR_W'(1);
                        expire = (rem_q == DUR_W'(1));
                    end else begin
                        ps_d = ps_q + PS_W'(1);
                    end
                end
                if (expire) begin
                    state_d   = DONE;
                    grant_d   = '0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            ps_q      <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            ps_q      <= ps_d;
            rem_q     <= rem_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

`ifdef TIMER_SCHED_STATUS_EN
    // Losers present at grant time; any still waiting at expiry waited a whole run.
    logic [NUM_REQ-1:0] pend_q;
    logic               ovr_q;

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            pend_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && win_vld) pend_q <= req & ~grant_d;
            if (expire && |(pend_q & req)) ovr_q <= 1'b1;
        end
    end

    assign remaining_out = (state_q == RUN) ? rem_q : '0;
    assign overrun       = ovr_q;
`endif

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: a per-cycle vector table for one timed run, then hand-written
// sequences for round-robin order, zero duration, withdraw, reset mid-run and sparse ticks.
module tb_timer_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        tick_a, tick_b;
    logic [3:0]  req_a, req_b;
    logic [47:0] dur_a, dur_b;
    logic [3:0]  grant_a, grant_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [1:0]  id_a, id_b;
`ifdef TIMER_SCHED_STATUS_EN
    logic [11:0] rem_a, rem_b;
    logic        ovr_a, ovr_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    timer_sched #(.NUM_REQ(4), .DUR_W(12), .PRESCALE(4)) dut_a (
        .clk_100Mhz(clk), .reset(reset), .tick_in(tick_a), .req(req_a), .dur(dur_a),
        .grant(grant_a), .busy(busy_a), .done(done_a),
`ifdef TIMER_SCHED_STATUS_EN
        .remaining_out(rem_a), .overrun(ovr_a),
`endif
        .done_id(id_a)
    );

    timer_sched #(.NUM_REQ(4), .DUR_W(12), .PRESCALE(2)) dut_b (
        .clk_100Mhz(clk), .reset(reset), .tick_in(tick_b), .req(req_b), .dur(dur_b),
        .grant(grant_b), .busy(busy_b), .done(done_b),
`ifdef TIMER_SCHED_STATUS_EN
        .remaining_out(rem_b), .overrun(ovr_b),
`endif
        .done_id(id_b)
    );

    typedef struct {
        logic [3:0] req;
        logic       tick;
        logic [3:0] grant;
        logic       busy;
        logic       done;
        logic [1:0] id;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [3:0] r, logic t, logic [3:0] g, logic b, logic d, logic [1:0] id);
        vec_t v;
        v.req = r; v.tick = t; v.grant = g; v.busy = b; v.done = d; v.id = id;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dur_a(input int i, input logic [11:0] v);
        dur_a[i*12 +: 12] = v;
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant_a == 4'b0 && n < 80) begin
            step();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done_a && n < 80) begin
            step();
            n++;
        end
    endtask

    // Serve one requester: expect it to be granted next, wait for its done, then release it.
    task automatic run_one(input int exp);
        int n;
        wait_grant(n);
        chk($sformatf("rr_grant_%0d", exp), 32'(grant_a), 32'(1) << exp);
        wait_done(n);
        chk($sformatf("rr_done_%0d", exp), 32'(done_a), 32'd1);
        chk($sformatf("rr_done_id_%0d", exp), 32'(id_a), 32'(exp));
        req_a[exp] = 1'b0;
    endtask

    initial begin
        int n;
        int early;
        int dones;

        reset = 1'b1;
        tick_a = 1'b0; tick_b = 1'b0;
        req_a = '0; req_b = '0;
        dur_a = '0; dur_b = '0;
        step(); step();
        chk("rst_grant", 32'(grant_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_done_id", 32'(id_a), 32'd0);
        reset = 1'b0;

        // PRESCALE=4, tick every cycle, dur=3: grant at cycle 1, done at 13, idle at 14.
        set_dur_a(0, 12'd3);
        for (int k = 0; k <= 11; k++) tv.push_back(mk(4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0));
        tv.push_back(mk(4'b0001, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0));
        tv.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0));
        tv.push_back(mk(4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0));
        foreach (tv[k]) begin
            req_a  = tv[k].req;
            tick_a = tv[k].tick;
            step();
            chk($sformatf("vec%0d_grant", k), 32'(grant_a), 32'(tv[k].grant));
            chk($sformatf("vec%0d_busy", k), 32'(busy_a), 32'(tv[k].busy));
            chk($sformatf("vec%0d_done", k), 32'(done_a), 32'(tv[k].done));
            if (tv[k].done) chk($sformatf("vec%0d_id", k), 32'(id_a), 32'(tv[k].id));
        end

        // Round robin from a fresh pointer.
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 4; i++) set_dur_a(i, 12'd1);
        req_a = 4'b1010;
        run_one(1);
        req_a = 4'b1000;
        run_one(3);
        req_a = 4'b1111;
        run_one(0);
        run_one(1);
        run_one(2);
        run_one(3);
        step(); step();

        // Zero duration on requester 2.
        set_dur_a(2, 12'd0);
        req_a = 4'b0100;
        step();
        chk("dur0_grant", 32'(grant_a), 32'h4);
        chk("dur0_busy1", 32'(busy_a), 32'd1);
        step();
        chk("dur0_done", 32'(done_a), 32'd1);
        chk("dur0_done_id", 32'(id_a), 32'd2);
        chk("dur0_grant_off", 32'(grant_a), 32'd0);
        req_a = 4'b0000;
        step();
        chk("dur0_busy0", 32'(busy_a), 32'd0);

        // Withdraw: requester 1 (dur=5) drops req at cycle 6, pending requester 2 follows.
        set_dur_a(1, 12'd5);
        req_a = 4'b0110;
        dones = 0;
        step();
        chk("wd_grant1", 32'(grant_a), 32'h2);
        for (int c = 2; c <= 6; c++) begin
            step();
            if (done_a) dones++;
        end
        req_a = 4'b0100;
        step();
        chk("wd_grant0", 32'(grant_a), 32'd0);
        chk("wd_busy0", 32'(busy_a), 32'd0);
        if (done_a) dones++;
        step();
        if (done_a) dones++;
        chk("wd_no_done", 32'(dones), 32'd0);
        chk("wd_next_grant", 32'(grant_a), 32'h4);
        step();
        chk("wd_next_done_id", 32'(id_a), 32'd2);
        req_a = 4'b0000;
        step();

        // Reset mid-run with remaining=7 clears outputs and the rr pointer.
        set_dur_a(2, 12'd7);
        req_a = 4'b0100;
        step();
        chk("rmr_grant", 32'(grant_a), 32'h4);
        step(); step();
        reset = 1'b1;
        step();
        chk("rmr_grant0", 32'(grant_a), 32'd0);
        chk("rmr_busy0", 32'(busy_a), 32'd0);
        chk("rmr_done0", 32'(done_a), 32'd0);
        chk("rmr_id0", 32'(id_a), 32'd0);
        reset = 1'b0;
        req_a = 4'b1001;
        step();
        chk("rmr_rr_grant", 32'(grant_a), 32'h1);
        req_a = 4'b0000;
        step(); step();

        // Sparse ticks on PRESCALE=2: ticks at cycles 0,10,20,30,40, grant at 1, done at 41.
        dur_b[11:0] = 12'd2;
        early = 0;
        for (int c = 0; c <= 40; c++) begin
            tick_b = (c % 10 == 0);
            req_b  = 4'b0001;
            step();
            if (c + 1 == 1) chk("sp_grant", 32'(grant_b), 32'h1);
            if (c + 1 < 41 && done_b) early++;
        end
        chk("sp_no_early_done", 32'(early), 32'd0);
        chk("sp_done", 32'(done_b), 32'd1);
        chk("sp_done_id", 32'(id_b), 32'd0);
        req_b  = 4'b0000;
        tick_b = 1'b0;
        step();
        step();
        chk("sp_idle", 32'(busy_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
